// File: rtl/slip_pkg.sv
// slip_pkg: SLIP byte constants and FSM state types shared by the link codec.
package slip_pkg;
    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    typedef enum logic [2:0] {TX_IDLE, TX_FETCH, TX_SEND, TX_SEND2, TX_SENDEND} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_FETCH, RX_DEC} rx_state_t;

    function automatic logic needs_esc(input logic [7:0] b);
        return (b == SLIP_END) || (b == SLIP_ESC);
    endfunction
endpackage

// File: rtl/slip_link_codec_decoder.sv
// slip_decoder: RX SLIP deframing; strips END/ESC, drops frames after a bad escape, counts frames and errors.
module slip_decoder
    import slip_pkg::*;
#(
    parameter int ERR_W = 8,
    parameter int FRM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_rdempty,
    input  logic [7:0]       i_rddata,
    output logic             o_rden,
    input  logic             i_wrfull,
    output logic             o_wren,
    output logic [7:0]       o_wrdata,
    output logic [FRM_W-1:0] o_frames,
    output logic [ERR_W-1:0] o_errs
);
    rx_state_t        r_state;
    logic [7:0]       r_byte;
    logic             r_esc;
    logic             r_drop;
    logic             r_cnt;
    logic             r_run;
    logic [FRM_W-1:0] r_frames;
    logic [ERR_W-1:0] r_errs;
    logic             w_is_end;
    logic             w_esc_ok;
    logic             w_need_wr;
    logic             w_dec;
    logic             w_wr;

    assign w_is_end  = (r_byte == SLIP_END);
    assign w_esc_ok  = (r_byte == SLIP_ESC_END) || (r_byte == SLIP_ESC_ESC);
    assign w_need_wr = !w_is_end && !r_drop && (r_esc ? w_esc_ok : (r_byte != SLIP_ESC));
    // DEC stalls only when it actually has a byte to write into a full FIFO.
    assign w_dec     = (r_state == RX_DEC) && !(w_need_wr && i_wrfull);
    assign w_wr      = w_dec && w_need_wr;
    assign o_wren    = w_wr;
    assign o_wrdata  = !w_wr ? 8'h00 : !r_esc ? r_byte : (r_byte == SLIP_ESC_END) ? SLIP_END : SLIP_ESC;
    assign o_rden    = r_run && (r_state == RX_IDLE) && i_en && !i_rdempty;
    assign o_frames  = r_frames;
    assign o_errs    = r_errs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RX_IDLE;
            r_byte   <= 8'h00;
            r_esc    <= 1'b0;
            r_drop   <= 1'b0;
            r_cnt    <= 1'b0;
            r_run    <= 1'b0;
            r_frames <= '0;
            r_errs   <= '0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                RX_IDLE: if (o_rden) r_state <= RX_FETCH;
                RX_FETCH: begin
                    r_byte  <= i_rddata;
                    r_state <= RX_DEC;
                end
                RX_DEC: begin
                    if (w_dec) begin
                        r_state <= RX_IDLE;
                        if (w_need_wr) r_cnt <= 1'b1;
                        if (w_is_end) begin
                            if (r_cnt && !r_drop) r_frames <= r_frames + 1'b1;
                            r_cnt  <= 1'b0;
                            r_esc  <= 1'b0;
                            r_drop <= 1'b0;
                        end else if (!r_drop && r_esc) begin
                            r_esc <= 1'b0;
                            if (!w_esc_ok) begin
                                r_drop <= 1'b1;
                                if (r_errs != '1) r_errs <= r_errs + 1'b1;
                            end
                        end else if (!r_drop && (r_byte == SLIP_ESC)) begin
                            r_esc <= 1'b1;
                        end
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/slip_link_codec_encoder.sv
// slip_encoder: TX SLIP framing; escapes reserved bytes and closes bursts with END after an idle gap.
module slip_encoder
    import slip_pkg::*;
#(
    parameter int IDLE_CYC = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic       i_rdempty,
    input  logic [7:0] i_rddata,
    output logic       o_rden,
    input  logic       i_wrfull,
    output logic       o_wren,
    output logic [7:0] o_wrdata,
    output logic       o_busy
);
    localparam int CW = $clog2(IDLE_CYC + 1);

    tx_state_t     r_state;
    logic [7:0]    r_byte;
    logic          r_pending;
    logic          r_run;
    logic [CW-1:0] r_idle;
    logic          w_fetch;
    logic          w_end_due;
    logic          w_put;

    // r_run keeps the read strobe low while reset is held and for the first edge after it.
    assign w_fetch   = r_run && (r_state == TX_IDLE) && i_en && !i_rdempty;
    assign w_end_due = r_pending && (r_idle == CW'(IDLE_CYC - 1));
    assign w_put     = !i_wrfull && ((r_state == TX_SEND) || (r_state == TX_SEND2) || (r_state == TX_SENDEND));
    assign o_rden    = w_fetch;
    assign o_wren    = w_put;
    assign o_busy    = (r_state != TX_IDLE) || r_pending;
    assign o_wrdata  = !w_put                   ? 8'h00 :
                       (r_state == TX_SENDEND)  ? SLIP_END :
                       (r_state == TX_SEND2)    ? ((r_byte == SLIP_END) ? SLIP_ESC_END : SLIP_ESC_ESC) :
                       needs_esc(r_byte)        ? SLIP_ESC : r_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= TX_IDLE;
            r_byte    <= 8'h00;
            r_pending <= 1'b0;
            r_run     <= 1'b0;
            r_idle    <= '0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                TX_IDLE: begin
                    if (w_fetch) begin
                        r_state <= TX_FETCH;
                        r_idle  <= '0;
                    end else if (w_end_due) begin
                        r_state <= TX_SENDEND;
                    end else if (r_pending) begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
                TX_FETCH: begin
                    r_byte  <= i_rddata;
                    r_state <= TX_SEND;
                end
                TX_SEND: begin
                    if (w_put) begin
                        r_state <= needs_esc(r_byte) ? TX_SEND2 : TX_IDLE;
                        if (!needs_esc(r_byte)) r_pending <= 1'b1;
                    end
                end
                TX_SEND2: begin
                    if (w_put) begin
                        r_pending <= 1'b1;
                        r_state   <= TX_IDLE;
                    end
                end
                TX_SENDEND: begin
                    if (w_put) begin
                        r_pending <= 1'b0;
                        r_state   <= TX_IDLE;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/slip_link_codec.sv
// slip_link_codec: SLIP link layer between the host FIFO arbiter and the transport FIFOs.
// TX and RX paths are fully independent and share only clock, reset and enable.
module slip_link_codec
    import slip_pkg::*;
#(
    parameter int IDLE_CYC = 64,
    parameter int ERR_W    = 8,
    parameter int FRM_W    = 16
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             EN,
    output logic             TXI_RDEN,
    input  logic             TXI_RDEMPTY,
    input  logic [7:0]       TXI_RDDATA,
    output logic             TXO_WREN,
    input  logic             TXO_WRFULL,
    output logic [7:0]       TXO_WRDATA,
    output logic             RXI_RDEN,
    input  logic             RXI_RDEMPTY,
    input  logic [7:0]       RXI_RDDATA,
    output logic             RXO_WREN,
    input  logic             RXO_WRFULL,
    output logic [7:0]       RXO_WRDATA,
    output logic [FRM_W-1:0] FRAMES_RX,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             TX_BUSY
);
    slip_encoder #(.IDLE_CYC(IDLE_CYC)) u_enc (
        .clk       (CLK),
        .rst_n     (RESETn),
        .i_en      (EN),
        .i_rdempty (TXI_RDEMPTY),
        .i_rddata  (TXI_RDDATA),
        .o_rden    (TXI_RDEN),
        .i_wrfull  (TXO_WRFULL),
        .o_wren    (TXO_WREN),
        .o_wrdata  (TXO_WRDATA),
        .o_busy    (TX_BUSY)
    );

    slip_decoder #(.ERR_W(ERR_W), .FRM_W(FRM_W)) u_dec (
        .clk       (CLK),
        .rst_n     (RESETn),
        .i_en      (EN),
        .i_rdempty (RXI_RDEMPTY),
        .i_rddata  (RXI_RDDATA),
        .o_rden    (RXI_RDEN),
        .i_wrfull  (RXO_WRFULL),
        .o_wren    (RXO_WREN),
        .o_wrdata  (RXO_WRDATA),
        .o_frames  (FRAMES_RX),
        .o_errs    (ERR_CNT)
    );
endmodule
